// File: rtl/secded_pkg.sv
// SECDED (13,8)+spare codeword layout, error classes and encode/syndrome helpers
// shared by the scrubber and the array wrapper.
package secded_pkg;

    localparam int CW_W      = 14;
    localparam int DATA_W    = 8;
    localparam int SYN_W     = 4;
    localparam int SPARE_BIT = 13;

    // Hamming positions of the check bits and of data bits d0..d7.
    localparam logic [3:0][3:0] CHK_POS  = {4'd8, 4'd4, 4'd2, 4'd1};
    localparam logic [7:0][3:0] DATA_POS = {4'd12, 4'd11, 4'd10, 4'd9,
                                            4'd7, 4'd6, 4'd5, 4'd3};

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        CE    = 2'd1,
        UE    = 2'd2
    } err_class_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_DEC  = 3'd3,
        ST_WR   = 3'd4,
        ST_NEXT = 3'd5
    } scrub_state_e;

    function automatic logic [SYN_W-1:0] secded_syndrome(input logic [CW_W-1:0] cw);
        logic [SYN_W-1:0] s;
        s = '0;
        for (int p = 1; p <= 12; p++) begin
            for (int k = 0; k < SYN_W; k++) begin
                if (p[k]) s[k] = s[k] ^ cw[p];
            end
        end
        return s;
    endfunction

    function automatic logic [CW_W-1:0] secded_encode(input logic [DATA_W-1:0] d);
        logic [CW_W-1:0]  cw;
        logic [SYN_W-1:0] s;
        cw = '0;
        for (int i = 0; i < DATA_W; i++) cw[DATA_POS[i]] = d[i];
        // With check bits still zero, the syndrome is exactly the check-bit vector.
        s = secded_syndrome(cw);
        for (int k = 0; k < SYN_W; k++) cw[CHK_POS[k]] = s[k];
        cw[0] = ^cw[12:1];
        return cw;
    endfunction

endpackage

// File: rtl/secded_decoder.sv
// Combinational SECDED decoder: classifies a stored codeword and forms the
// corrected codeword (spare bit forced to 0).
module secded_decoder
    import secded_pkg::*;
(
    input  logic [CW_W-1:0]  cw_i,
    output logic [SYN_W-1:0] syn_o,
    output err_class_e       class_o,
    output logic [CW_W-1:0]  corr_o
);

    logic [SYN_W-1:0] syn;
    logic             parity;

    always_comb begin
        syn     = secded_syndrome(cw_i);
        parity  = ^cw_i[12:0];
        class_o = CLEAN;
        corr_o  = cw_i;
        if (parity) begin
            if (syn == '0) begin
                class_o   = CE;
                corr_o[0] = ~cw_i[0];
            end else if (syn <= 4'd12) begin
                class_o     = CE;
                corr_o[syn] = ~cw_i[syn];
            end else begin
                class_o = UE;
            end
        end else if (syn != '0) begin
            class_o = UE;
        end
        corr_o[SPARE_BIT] = 1'b0;
        syn_o = syn;
    end

endmodule

// File: rtl/sram_scrubber.sv
// Background SECDED scrubber: walks the array, rewrites single-bit errors,
// logs uncorrectable ones.
module sram_scrubber #(
    parameter int ADDR_W   = 8,
    parameter int CW_W     = 14,
    parameter int INTERVAL = 1024,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scrub_en,
    output logic              scrub_req,
    input  logic              scrub_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CW_W-1:0]   mem_wdata,
    input  logic [CW_W-1:0]   mem_rdata,
    output logic [CNT_W-1:0]  ce_count,
    output logic [CNT_W-1:0]  ue_count,
    output logic [ADDR_W-1:0] ue_addr,
    output logic              sweep_done,
    output logic [2:0]        dbg_state,
    output logic [3:0]        dbg_syndrome
);
    import secded_pkg::*;

    localparam int              IVL_W    = $clog2(INTERVAL + 1);
    localparam logic [IVL_W-1:0] IVL_LOAD = IVL_W'(INTERVAL);

    scrub_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IVL_W-1:0]  ivl_q, ivl_d;
    logic [CW_W-1:0]   rdata_q, rdata_d;
    logic [CW_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]  ce_q, ce_d, ue_q, ue_d;
    logic [ADDR_W-1:0] ue_addr_q, ue_addr_d;
    logic [SYN_W-1:0]  syn_q, syn_d;
    logic              req_q, req_d, we_q, we_d, done_q, done_d;

    logic [SYN_W-1:0]  dec_syn;
    err_class_e        dec_class;
    logic [CW_W-1:0]   dec_corr;

    secded_decoder u_dec (
        .cw_i    (rdata_q),
        .syn_o   (dec_syn),
        .class_o (dec_class),
        .corr_o  (dec_corr)
    );

    // Handshake: scrub_req is held from RD/WR entry until the cycle scrub_gnt is
    // seen high with it; that cycle is the array access (mem_en). A grant while
    // scrub_req is low carries no meaning and is ignored.
    assign mem_en = scrub_req && scrub_gnt;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        ivl_d     = ivl_q;
        rdata_d   = rdata_q;
        wdata_d   = wdata_q;
        ce_d      = ce_q;
        ue_d      = ue_q;
        ue_addr_d = ue_addr_q;
        syn_d     = syn_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scrub_en) begin
                    if (ivl_q == '0) state_d = ST_RD;
                    else             ivl_d   = ivl_q - 1'b1;
                end
            end
            ST_RD:   if (mem_en) state_d = ST_WAIT;
            ST_WAIT: begin
                // Array output is valid here, one cycle after the granted read.
                rdata_d = mem_rdata;
                state_d = ST_DEC;
            end
            ST_DEC: begin
                syn_d   = dec_syn;
                state_d = ST_NEXT;
                if (dec_class == CE) begin
                    wdata_d = dec_corr;
                    ce_d    = (&ce_q) ? ce_q : ce_q + 1'b1;
                    state_d = ST_WR;
                end else if (dec_class == UE) begin
                    ue_d      = (&ue_q) ? ue_q : ue_q + 1'b1;
                    ue_addr_d = addr_q;
                end
            end
            ST_WR:   if (mem_en) state_d = ST_NEXT;
            ST_NEXT: begin
                addr_d  = addr_q + 1'b1;
                done_d  = &addr_q;
                ivl_d   = IVL_LOAD;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        req_d = (state_d == ST_RD) || (state_d == ST_WR);
        we_d  = (state_d == ST_WR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            ivl_q     <= IVL_LOAD;
            rdata_q   <= '0;
            wdata_q   <= '0;
            ce_q      <= '0;
            ue_q      <= '0;
            ue_addr_q <= '0;
            syn_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            ivl_q     <= ivl_d;
            rdata_q   <= rdata_d;
            wdata_q   <= wdata_d;
            ce_q      <= ce_d;
            ue_q      <= ue_d;
            ue_addr_q <= ue_addr_d;
            syn_q     <= syn_d;
            req_q     <= req_d;
            we_q      <= we_d;
            done_q    <= done_d;
        end
    end

    assign scrub_req    = req_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign ce_count     = ce_q;
    assign ue_count     = ue_q;
    assign ue_addr      = ue_addr_q;
    assign sweep_done   = done_q;
    assign dbg_state    = state_q;
    assign dbg_syndrome = syn_q;

endmodule

// File: tb/tb_sram_scrubber.sv
// Directed bench for sram_scrubber: array model, per-scenario tasks with inline checks.
module tb_sram_scrubber;
    import secded_pkg::*;

    localparam logic [13:0] GOOD = 14'h06C5;
    localparam logic [13:0] CE6  = 14'h0685;
    localparam logic [13:0] UE67 = 14'h0605;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scrub_en = 1'b0;
    logic        scrub_gnt = 1'b1;
    logic        scrub_req, mem_en, mem_we, sweep_done;
    logic [7:0]  mem_addr, ue_addr;
    logic [13:0] mem_wdata;
    logic [13:0] mem_rdata = GOOD;
    logic [15:0] ce_count, ue_count;
    logic [2:0]  dbg_state;
    logic [3:0]  dbg_syndrome;

    // second, narrow-counter instance that sees a single-bit error on every read
    logic        sat_req, sat_gnt, sat_mem_en, sat_we, sat_done;
    logic [2:0]  sat_addr, sat_ue_addr, sat_dbg_state;
    logic [13:0] sat_wdata;
    logic [1:0]  sat_ce, sat_ue;
    logic [3:0]  sat_dbg_syn;
    assign sat_gnt = sat_req;

    logic [13:0] mem [256];
    logic        init_mem = 1'b0;
    logic        plant_en = 1'b0;
    logic [7:0]  plant_addr = 8'd0;
    logic [13:0] plant_data = 14'd0;

    int reads = 0, writes = 0, sd_cnt = 0, sat_writes = 0;
    logic [7:0]  last_waddr = 8'd0, sd_addr = 8'd0;
    logic [13:0] last_wdata = 14'd0;
    logic [1:0]  sat_prev = 2'd0;
    logic        sat_wrapped = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    sram_scrubber #(.ADDR_W(8), .CW_W(14), .INTERVAL(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .scrub_en(scrub_en), .scrub_req(scrub_req),
        .scrub_gnt(scrub_gnt), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .ce_count(ce_count), .ue_count(ue_count), .ue_addr(ue_addr),
        .sweep_done(sweep_done), .dbg_state(dbg_state), .dbg_syndrome(dbg_syndrome)
    );

    sram_scrubber #(.ADDR_W(3), .CW_W(14), .INTERVAL(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .scrub_en(1'b1), .scrub_req(sat_req),
        .scrub_gnt(sat_gnt), .mem_en(sat_mem_en), .mem_we(sat_we),
        .mem_addr(sat_addr), .mem_wdata(sat_wdata), .mem_rdata(CE6),
        .ce_count(sat_ce), .ue_count(sat_ue), .ue_addr(sat_ue_addr),
        .sweep_done(sat_done), .dbg_state(sat_dbg_state), .dbg_syndrome(sat_dbg_syn)
    );

    always #5 clk = ~clk;

    // array model: one-cycle read latency, output holds between reads
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= GOOD;
            mem[20] <= CE6;
            mem[40] <= UE67;
        end else if (plant_en) begin
            mem[plant_addr] <= plant_data;
        end else if (mem_en && !mem_we) begin
            mem_rdata <= mem[mem_addr];
            reads     <= reads + 1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr] <= mem_wdata;
            writes        <= writes + 1;
            last_waddr    <= mem_addr;
            last_wdata    <= mem_wdata;
        end
        if (sat_mem_en && sat_we) sat_writes <= sat_writes + 1;
    end

    always @(negedge clk) begin
        if (sweep_done) begin
            sd_cnt  <= sd_cnt + 1;
            sd_addr <= mem_addr;
        end
        if (!rst) begin
            if (sat_prev == 2'd3 && sat_ce != 2'd3) sat_wrapped <= 1'b1;
            sat_prev <= sat_ce;
        end
    end

    task automatic test_reset();
        rst = 1'b1; scrub_en = 1'b0; scrub_gnt = 1'b1; init_mem = 1'b1;
        repeat (3) @(negedge clk);
        init_mem = 1'b0;
        vectors++; if (scrub_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %0b expected 0", scrub_req); end
        vectors++; if (mem_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en: got %0b expected 0", mem_en); end
        vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %0b expected 0", mem_we); end
        vectors++; if (mem_addr !== 8'd0) begin miscompares++; $display("FAIL reset_addr: got %0h expected 0", mem_addr); end
        vectors++; if (mem_wdata !== 14'd0) begin miscompares++; $display("FAIL reset_wdata: got %0h expected 0", mem_wdata); end
        vectors++; if (ce_count !== 16'd0 || ue_count !== 16'd0) begin miscompares++; $display("FAIL reset_counts: got ce=%0h ue=%0h expected 0/0", ce_count, ue_count); end
        vectors++; if (ue_addr !== 8'd0) begin miscompares++; $display("FAIL reset_ue_addr: got %0h expected 0", ue_addr); end
        vectors++; if (sweep_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", sweep_done); end
        vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        vectors++; if (secded_encode(8'h3C) !== GOOD) begin miscompares++; $display("FAIL encode_3c: got %0h expected %0h", secded_encode(8'h3C), GOOD); end
    endtask

    task automatic test_clean_pass();
        scrub_en = 1'b1;
        rst = 1'b0;
        for (int a = 1; a <= 3; a++) begin
            for (int i = 0; i < 20 && mem_addr !== 8'(a); i++) @(negedge clk);
            vectors++; if (mem_addr !== 8'(a)) begin miscompares++; $display("FAIL clean_advance: got addr %0d expected %0d", mem_addr, a); end
        end
        vectors++; if (reads !== 3) begin miscompares++; $display("FAIL clean_reads: got %0d expected 3", reads); end
        vectors++; if (writes !== 0) begin miscompares++; $display("FAIL clean_no_write: got %0d expected 0", writes); end
        vectors++; if (ce_count !== 16'd0 || ue_count !== 16'd0) begin miscompares++; $display("FAIL clean_counts: got ce=%0h ue=%0h expected 0/0", ce_count, ue_count); end
    endtask

    task automatic test_correctable();
        for (int i = 0; i < 400 && mem_addr !== 8'd21; i++) @(negedge clk);
        vectors++; if (mem_addr !== 8'd21) begin miscompares++; $display("FAIL ce_reach: got addr %0d expected 21", mem_addr); end
        vectors++; if (writes !== 1) begin miscompares++; $display("FAIL ce_writes: got %0d expected 1", writes); end
        vectors++; if (last_waddr !== 8'd20) begin miscompares++; $display("FAIL ce_waddr: got %0d expected 20", last_waddr); end
        vectors++; if (last_wdata !== GOOD) begin miscompares++; $display("FAIL ce_wdata: got %0h expected %0h", last_wdata, GOOD); end
        vectors++; if (ce_count !== 16'd1) begin miscompares++; $display("FAIL ce_count: got %0d expected 1", ce_count); end
        vectors++; if (dbg_syndrome !== 4'd6) begin miscompares++; $display("FAIL ce_syndrome: got %0d expected 6", dbg_syndrome); end
    endtask

    task automatic test_uncorrectable();
        for (int i = 0; i < 400 && mem_addr !== 8'd41; i++) @(negedge clk);
        vectors++; if (mem_addr !== 8'd41) begin miscompares++; $display("FAIL ue_reach: got addr %0d expected 41", mem_addr); end
        vectors++; if (writes !== 1) begin miscompares++; $display("FAIL ue_no_write: got %0d expected 1", writes); end
        vectors++; if (ue_count !== 16'd1) begin miscompares++; $display("FAIL ue_count: got %0d expected 1", ue_count); end
        vectors++; if (ue_addr !== 8'd40) begin miscompares++; $display("FAIL ue_addr: got %0d expected 40", ue_addr); end
        vectors++; if (ce_count !== 16'd1) begin miscompares++; $display("FAIL ue_ce_kept: got %0d expected 1", ce_count); end
        vectors++; if (dbg_syndrome !== 4'd1) begin miscompares++; $display("FAIL ue_syndrome: got %0d expected 1", dbg_syndrome); end
    endtask

    task automatic test_grant_withheld();
        int  r0;
        logic bad_req, bad_en, bad_addr;
        scrub_gnt = 1'b0;
        for (int i = 0; i < 20 && scrub_req !== 1'b1; i++) @(negedge clk);
        vectors++; if (scrub_req !== 1'b1) begin miscompares++; $display("FAIL hold_req_rise: got %0b expected 1", scrub_req); end
        r0 = reads;
        bad_req = 1'b0; bad_en = 1'b0; bad_addr = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (scrub_req !== 1'b1) bad_req = 1'b1;
            if (mem_en !== 1'b0) bad_en = 1'b1;
            if (mem_addr !== 8'd41) bad_addr = 1'b1;
        end
        vectors++; if (bad_req !== 1'b0) begin miscompares++; $display("FAIL hold_req: got drop=%0b expected 0", bad_req); end
        vectors++; if (bad_en !== 1'b0) begin miscompares++; $display("FAIL hold_mem_en: got seen=%0b expected 0", bad_en); end
        vectors++; if (bad_addr !== 1'b0) begin miscompares++; $display("FAIL hold_addr: got moved=%0b expected 0", bad_addr); end
        vectors++; if (reads !== r0) begin miscompares++; $display("FAIL hold_no_read: got %0d expected %0d", reads, r0); end
        scrub_gnt = 1'b1;
        repeat (4) @(negedge clk);
        vectors++; if (reads !== r0 + 1) begin miscompares++; $display("FAIL grant_one_read: got %0d expected %0d", reads, r0 + 1); end
        vectors++; if (mem_addr !== 8'd42) begin miscompares++; $display("FAIL grant_advance: got %0d expected 42", mem_addr); end
    endtask

    task automatic test_saturation();
        repeat (200) @(negedge clk);
        vectors++; if (sat_writes < 4) begin miscompares++; $display("FAIL sat_activity: got %0d writes expected at least 4", sat_writes); end
        vectors++; if (sat_ce !== 2'd3) begin miscompares++; $display("FAIL sat_ce: got %0d expected 3", sat_ce); end
        vectors++; if (sat_wrapped !== 1'b0) begin miscompares++; $display("FAIL sat_no_wrap: got %0b expected 0", sat_wrapped); end
        vectors++; if (sat_ue !== 2'd0) begin miscompares++; $display("FAIL sat_ue: got %0d expected 0", sat_ue); end
    endtask

    task automatic test_sweep();
        int w0;
        vectors++; if (sd_cnt !== 0) begin miscompares++; $display("FAIL sweep_early: got %0d pulses expected 0", sd_cnt); end
        plant_addr = 8'd5; plant_data = CE6; plant_en = 1'b1;
        @(negedge clk);
        plant_en = 1'b0;
        w0 = writes;
        for (int i = 0; i < 4000 && sd_cnt == 0; i++) @(negedge clk);
        for (int i = 0; i < 40 && mem_addr !== 8'd2; i++) @(negedge clk);
        vectors++; if (sd_cnt !== 1) begin miscompares++; $display("FAIL sweep_pulses: got %0d expected 1", sd_cnt); end
        vectors++; if (sd_addr !== 8'd0) begin miscompares++; $display("FAIL sweep_wrap_addr: got %0d expected 0", sd_addr); end
        vectors++; if (mem_addr !== 8'd2) begin miscompares++; $display("FAIL sweep_after: got %0d expected 2", mem_addr); end
        vectors++; if (writes !== w0) begin miscompares++; $display("FAIL sweep_no_write: got %0d expected %0d", writes, w0); end
    endtask

    task automatic test_reset_in_write();
        int w0;
        for (int i = 0; i < 100 && mem_we !== 1'b1; i++) @(negedge clk);
        vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL wr_reach: got we=%0b expected 1", mem_we); end
        vectors++; if (mem_addr !== 8'd5) begin miscompares++; $display("FAIL wr_addr: got %0d expected 5", mem_addr); end
        scrub_gnt = 1'b0;
        w0 = writes;
        #2 rst = 1'b1;
        #1;
        vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        vectors++; if (mem_addr !== 8'd0) begin miscompares++; $display("FAIL rst_addr: got %0d expected 0", mem_addr); end
        vectors++; if (ce_count !== 16'd0 || ue_count !== 16'd0) begin miscompares++; $display("FAIL rst_counts: got ce=%0h ue=%0h expected 0/0", ce_count, ue_count); end
        vectors++; if (scrub_req !== 1'b0 || mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_req_we: got req=%0b we=%0b expected 0/0", scrub_req, mem_we); end
        scrub_gnt = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (writes !== w0) begin miscompares++; $display("FAIL rst_write_dropped: got %0d expected %0d", writes, w0); end
        vectors++; if (mem[5] !== CE6) begin miscompares++; $display("FAIL rst_mem_kept: got %0h expected %0h", mem[5], CE6); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_correctable();
        test_uncorrectable();
        test_grant_withheld();
        test_saturation();
        test_sweep();
        test_reset_in_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
